pe_arbiter: RTL and testbench
=============================

PE_ARBITER -- requirements
Module: pe_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per owner, legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 4 bits: request from requester i on req[i].
REQ-005 The block SHALL have port gnt, output, 4 bits: one-hot grant, all zero when no owner.
REQ-006 The block SHALL have ports y1 and y0, output, 1 bit each: binary index of the owner, {y1,y0}.
REQ-007 The block SHALL have port v, output, 1 bit: grant valid; high exactly when gnt is nonzero.

Function
REQ-008 The block SHALL drive all outputs from registers, with no combinational path from req to any output.
REQ-009 The block SHALL implement three states:
- IDLE
- GRANT
- RELEASE
REQ-010 In IDLE or RELEASE, at each edge, it SHALL go to GRANT with the arbitration winner as owner if req != 0.
- Otherwise it SHALL go to IDLE.
REQ-011 Grant latency SHALL be one cycle: req sampled at edge N gives gnt visible after edge N.
REQ-012 In GRANT, gnt[owner]=1, v=1 and {y1,y0}=owner SHALL hold constant.
- Requests from other requesters SHALL be ignored; there is no preemption.
REQ-013 A hold counter SHALL load 1 on entry to GRANT and increment on each further GRANT cycle.
REQ-014 GRANT SHALL go to RELEASE at the edge where req[owner]=0.
- It SHALL also go to RELEASE at the edge where the counter equals MAX_HOLD, whichever comes first.
- If both occur at the same edge, it SHALL take a single transition to RELEASE.
REQ-015 RELEASE SHALL last exactly one cycle, with gnt=0, v=0 and {y1,y0}=0.
- Consecutive grants are therefore always separated by one dead cycle.
REQ-016 In IDLE, outputs SHALL be gnt=0, v=0 and {y1,y0}=0.
REQ-017 With multi-hot req, exactly one winner SHALL be selected, per REQ-023/REQ-024.
REQ-018 With MAX_HOLD=1, every grant SHALL last exactly one cycle, followed by RELEASE.
REQ-019 A last_owner register SHALL update to the new owner on every entry to GRANT.

Reset
REQ-020 Asserting rst SHALL immediately, without waiting for clk, force:
- state to IDLE
- gnt=0, v=0, y1=0, y0=0
- hold counter to 0
- last_owner to 0
REQ-021 Reset asserted mid-GRANT SHALL drop gnt in the same cycle.
- After deassertion, arbitration SHALL restart from IDLE with no memory of the prior owner.
REQ-022 While rst is high, req SHALL be ignored.

Configuration
REQ-023 Without macro PE_ARB_RR_EN, arbitration SHALL be fixed priority: req[3] > req[2] > req[1] > req[0].
REQ-024 With PE_ARB_RR_EN defined, arbitration SHALL be round-robin.
- Search order SHALL be descending and start at (last_owner-1) mod 4, wrapping from 0 to 3.
- The previous owner SHALL have lowest priority.
- Because last_owner resets to 0, the first grant after reset matches fixed priority.

Verification
REQ-025 The bench SHALL cover a single request: req=0100 from IDLE, held 3 cycles, then 0000.
- Required: gnt=0100, {y1,y0}=10 and v=1 for 3 cycles, then one RELEASE cycle, then IDLE.
REQ-026 The bench SHALL cover priority: req=1011 from IDLE.
- Required: gnt=1000, {y1,y0}=11.
- Non-RR build: after release with req still 0011, next gnt=0010.
REQ-027 The bench SHALL cover hold timeout: MAX_HOLD=4, req=0001 held high continuously.
- Required: gnt=0001 for exactly 4 cycles, 0 for 1 cycle, then 0001 again, repeating.
REQ-028 The bench SHALL cover round-robin with PE_ARB_RR_EN: req=1111 held, MAX_HOLD=2.
- Required grant sequence: 1000, 0100, 0010, 0001, 1000, each 2 cycles and separated by a one-cycle gap.
REQ-029 The bench SHALL cover reset mid-grant: rst pulsed during gnt=0010 between clock edges.
- Required: gnt, v, y1 and y0 go to 0 before the next edge.
- After release with req=0010, gnt=0010 again one edge later.
REQ-030 The bench SHALL cover simultaneous events: owner deasserts req on the same edge the counter reaches MAX_HOLD.
- Required: exactly one RELEASE cycle, then a grant to the next winner.

Source files
------------

// File: rtl/pe_arbiter.sv
// Four-requester grant arbiter with a per-owner hold limit and a one-cycle dead gap between grants.
// Define PE_ARB_RR_EN for round-robin arbitration; the default build uses fixed priority req[3] > req[0].
module pe_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic       y1,
  output logic       y0,
  output logic       v
);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t     state;
  logic [7:0] hold_cnt;
  logic [1:0] owner;
  logic [1:0] win;

  // {y1,y0} only carries a nonzero value while in GRANT, so it doubles as the owner register.
  assign owner = {y1, y0};

`ifdef PE_ARB_RR_EN
  logic [1:0] last_owner;

  // Later iterations overwrite earlier ones, so the search position nearest last_owner-1 wins
  // and last_owner itself ends up with the lowest priority.
  function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] w;
    logic [1:0] idx;
    w = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last - 2'(k);
      if (r[idx]) w = idx;
    end
    return w;
  endfunction

  assign win = pick_winner(req, last_owner);
`else
  function automatic logic [1:0] pick_winner(input logic [3:0] r);
    logic [1:0] w;
    if (r[3])      w = 2'd3;
    else if (r[2]) w = 2'd2;
    else if (r[1]) w = 2'd1;
    else           w = 2'd0;
    return w;
  endfunction

  assign win = pick_winner(req);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      y1       <= 1'b0;
      y0       <= 1'b0;
      v        <= 1'b0;
      hold_cnt <= 8'd0;
`ifdef PE_ARB_RR_EN
      last_owner <= 2'd0;
`endif
    end else begin
      case (state)
        IDLE, RELEASE: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << win;
            {y1, y0} <= win;
            v        <= 1'b1;
            hold_cnt <= 8'd1;
`ifdef PE_ARB_RR_EN
            last_owner <= win;
`endif
          end else begin
            state    <= IDLE;
            gnt      <= 4'b0000;
            {y1, y0} <= 2'b00;
            v        <= 1'b0;
            hold_cnt <= 8'd0;
          end
        end
        GRANT: begin
          // Owner dropping its request and hitting the hold limit collapse into one release.
          if (!req[owner] || hold_cnt == 8'(MAX_HOLD)) begin
            state    <= RELEASE;
            gnt      <= 4'b0000;
            {y1, y0} <= 2'b00;
            v        <= 1'b0;
            hold_cnt <= 8'd0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          gnt      <= 4'b0000;
          {y1, y0} <= 2'b00;
          v        <= 1'b0;
          hold_cnt <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_arbiter.sv
// Bench for pe_arbiter: two instances (hold limits 4 and 2) against a behavioural grant model.
// Build with PE_ARB_RR_EN defined to exercise the round-robin variant.
module tb_pe_arbiter;

  localparam int MH_A = 4;
  localparam int MH_B = 2;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt_a, gnt_b;
  logic       y1_a, y0_a, v_a;
  logic       y1_b, y0_b, v_b;

  int n_checks = 0;
  int n_errors = 0;

  // Model: current owner (-1 when nobody holds the grant), cycles held, previous owner.
  int own  [2] = '{-1, -1};
  int held [2] = '{0, 0};
  int last [2] = '{0, 0};
  int mh   [2] = '{MH_A, MH_B};

  pe_arbiter #(.MAX_HOLD(MH_A)) dut_a (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_a), .y1(y1_a), .y0(y0_a), .v(v_a)
  );

  pe_arbiter #(.MAX_HOLD(MH_B)) dut_b (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt_b), .y1(y1_b), .y0(y0_b), .v(v_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_pick(input logic [3:0] r, input int lst);
`ifdef PE_ARB_RR_EN
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (lst + 4 - k) % 4;
      if (r[i]) return i;
    end
`else
    for (int i = 3; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic model_step(input int k);
    if (own[k] >= 0) begin
      if (!req[own[k]] || held[k] == mh[k]) own[k] = -1;
      else held[k]++;
    end else if (req != 4'b0000) begin
      own[k]  = model_pick(req, last[k]);
      held[k] = 1;
      last[k] = own[k];
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        own[k]  = -1;
        held[k] = 0;
        last[k] = 0;
      end
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic check_all();
    logic [3:0] eg;
    logic [1:0] ey;
    logic       ev;
    for (int k = 0; k < 2; k++) begin
      eg = 4'b0000;
      ey = 2'b00;
      ev = 1'b0;
      if (own[k] >= 0) begin
        eg[own[k]] = 1'b1;
        ey = 2'(own[k]);
        ev = 1'b1;
      end
      if (k == 0) begin
        check("a_gnt", gnt_a, eg);
        check("a_y",   {2'b00, y1_a, y0_a}, {2'b00, ey});
        check("a_v",   {3'b000, v_a}, {3'b000, ev});
      end else begin
        check("b_gnt", gnt_b, eg);
        check("b_y",   {2'b00, y1_b, y0_b}, {2'b00, ey});
        check("b_v",   {3'b000, v_b}, {3'b000, ev});
      end
    end
  endtask

  task automatic cyc(input logic [3:0] r);
    req = r;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

`ifdef PE_ARB_RR_EN
  logic [3:0] rr_tab [14] = '{4'b1000, 4'b1000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0010,
                              4'b0010, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b1000};
`endif

  initial begin
    logic [3:0] cur;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check("rst_gnt", gnt_a, 4'b0000);
    check("rst_v",   {3'b000, v_a}, 4'b0000);
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Single requester held three cycles.
    cyc(4'b0100);
    check("t25_gnt", gnt_a, 4'b0100);
    check("t25_y",   {2'b00, y1_a, y0_a}, 4'b0010);
    cyc(4'b0100);
    cyc(4'b0100);
    check("t25_gnt3", gnt_a, 4'b0100);
    cyc(4'b0000);
    check("t25_rel", gnt_a, 4'b0000);
    cyc(4'b0000);

    // Multi-hot priority, then the remaining requesters after release.
    cyc(4'b1011);
    check("t26_gnt", gnt_a, 4'b1000);
    check("t26_y",   {2'b00, y1_a, y0_a}, 4'b0011);
    cyc(4'b0011);
    check("t26_rel", gnt_a, 4'b0000);
    cyc(4'b0011);
    check("t26_next", gnt_a, 4'b0010);
    cyc(4'b0000);
    cyc(4'b0000);

    // Hold timeout with a continuous request.
    for (int i = 0; i < 12; i++) begin
      cyc(4'b0001);
      check("t27_gnt", gnt_a, (i % 5 == 4) ? 4'b0000 : 4'b0001);
    end
    cyc(4'b0000);
    cyc(4'b0000);

`ifdef PE_ARB_RR_EN
    for (int i = 0; i < 14; i++) begin
      cyc(4'b1111);
      check("t28_rr", gnt_b, rr_tab[i]);
    end
    cyc(4'b0000);
    cyc(4'b0000);
`endif

    // Asynchronous reset in the middle of a grant.
    cyc(4'b0010);
    check("t29_gnt", gnt_a, 4'b0010);
    #1 rst = 1'b1;
    #1;
    check("t29_rst_gnt", gnt_a, 4'b0000);
    check("t29_rst_v",   {3'b000, v_a}, 4'b0000);
    check("t29_rst_y",   {2'b00, y1_a, y0_a}, 4'b0000);
    check("t29_rst_gnt_b", gnt_b, 4'b0000);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_all();
    check("t29_regnt", gnt_a, 4'b0010);
    cyc(4'b0000);
    cyc(4'b0000);

    // Owner drops its request on the same edge the hold limit is reached.
    for (int i = 0; i < MH_A; i++) cyc(4'b0101);
    check("t30_hold", gnt_a, 4'b0100);
    cyc(4'b0001);
    check("t30_rel", gnt_a, 4'b0000);
    cyc(4'b0001);
    check("t30_next", gnt_a, 4'b0001);
    cyc(4'b0000);
    cyc(4'b0000);

    // Randomized traffic with occasional asynchronous resets.
    cur = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) cur = 4'($urandom_range(0, 15));
      cyc(cur);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst = 1'b1;
        #1 check_all();
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
